// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the single integer and the single float register-file
// write port among NREQ execution units. Each file has its own round-robin
// arbiter; at most one integer and one float writeback are granted per cycle,
// and the granted writes reach the core one cycle later from registers.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   req_valid[i]       requester i has a writeback pending
//   req_float[i]       1 = float file target, 0 = integer file target
//   req_reg, req_data  packed per-requester index / data (i*RW, i*DW)
//   req_ready[i]       combinational grant (transfer on valid & ready)
//   wb_hold            freeze: no grants this cycle
//   wgenable/wgreg/wgdata   registered integer write port to core
//   wfenable/wfreg/wfdata   registered float write port to core

// Round-robin picker with its own pointer; grant is combinational.
module wb_arbiter_rr #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned PW   = 2
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [NREQ-1:0] req,
   input  logic            hold,
   output logic [NREQ-1:0] gnt,
   output logic            gnt_any,
   output logic [PW-1:0]   gnt_idx
);

   localparam int unsigned LAST = NREQ - 1;

   logic [PW-1:0] ptr;
   logic          hit_hi;
   logic          hit_lo;
   logic [PW-1:0] idx_hi;
   logic [PW-1:0] idx_lo;

   // Two-pass scan: first requester at or above ptr, else lowest overall.
   always_comb begin
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      idx_hi = '0;
      idx_lo = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!hit_hi && req[i] && (PW'(i) >= ptr)) begin
            hit_hi = 1'b1;
            idx_hi = PW'(i);
         end
         if (!hit_lo && req[i]) begin
            hit_lo = 1'b1;
            idx_lo = PW'(i);
         end
      end
   end

   // Grant is suppressed during hold and while reset is asserted.
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (rstn && !hold && (hit_hi || hit_lo)) begin
         gnt_any = 1'b1;
         gnt_idx = hit_hi ? idx_hi : idx_lo;
         for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_idx == PW'(i)) begin
               gnt[i] = 1'b1;
            end
         end
      end
   end

   // Pointer moves just past the granted requester; holds otherwise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr <= '0;
      end else if (gnt_any) begin
         ptr <= (gnt_idx == PW'(LAST)) ? '0 : gnt_idx + PW'(1);
      end
   end

endmodule

module wb_arbiter #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned DW   = 32,
   parameter int unsigned RW   = 5
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_float,
   input  logic [NREQ*RW-1:0] req_reg,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   input  logic               wb_hold,
   output logic               wgenable,
   output logic [RW-1:0]      wgreg,
   output logic [DW-1:0]      wgdata,
   output logic               wfenable,
   output logic [RW-1:0]      wfreg,
   output logic [DW-1:0]      wfdata
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] int_req;
   logic [NREQ-1:0] flt_req;
   logic [NREQ-1:0] int_gnt;
   logic [NREQ-1:0] flt_gnt;
   logic            int_any;
   logic            flt_any;
   logic [PW-1:0]   int_idx;
   logic [PW-1:0]   flt_idx;
   logic [RW-1:0]   int_reg;
   logic [DW-1:0]   int_data;
   logic [RW-1:0]   flt_reg;
   logic [DW-1:0]   flt_data;

   // req_float steers each request into exactly one of the two groups.
   assign int_req = req_valid & ~req_float;
   assign flt_req = req_valid &  req_float;

   wb_arbiter_rr #(.NREQ(NREQ), .PW(PW)) u_int_rr (
      .clk     (clk),
      .rstn    (rstn),
      .req     (int_req),
      .hold    (wb_hold),
      .gnt     (int_gnt),
      .gnt_any (int_any),
      .gnt_idx (int_idx)
   );

   wb_arbiter_rr #(.NREQ(NREQ), .PW(PW)) u_flt_rr (
      .clk     (clk),
      .rstn    (rstn),
      .req     (flt_req),
      .hold    (wb_hold),
      .gnt     (flt_gnt),
      .gnt_any (flt_any),
      .gnt_idx (flt_idx)
   );

   assign req_ready = int_gnt | flt_gnt;

   // Select the payload of each group's winner.
   always_comb begin
      int_reg  = '0;
      int_data = '0;
      flt_reg  = '0;
      flt_data = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (int_idx == PW'(i)) begin
            int_reg  = req_reg[i*RW +: RW];
            int_data = req_data[i*DW +: DW];
         end
         if (flt_idx == PW'(i)) begin
            flt_reg  = req_reg[i*RW +: RW];
            flt_data = req_data[i*DW +: DW];
         end
      end
   end

   // Integer write port; writes to x0 are accepted but never enabled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wgenable <= 1'b0;
         wgreg    <= '0;
         wgdata   <= '0;
      end else if (int_any) begin
         wgenable <= (int_reg != '0);
         wgreg    <= int_reg;
         wgdata   <= int_data;
      end else begin
         wgenable <= 1'b0;
      end
   end

   // Float write port; f0 is a real register and is always written.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wfenable <= 1'b0;
         wfreg    <= '0;
         wfdata   <= '0;
      end else if (flt_any) begin
         wfenable <= 1'b1;
         wfreg    <= flt_reg;
         wfdata   <= flt_data;
      end else begin
         wfenable <= 1'b0;
      end
   end

endmodule
